// File: rtl/prim_onehot_mon_pkg.sv
// Shared FSM encoding and slice helper for the one-hot integrity monitor.
// Latency: none; this file holds declarations only.
// Backpressure: none; this file holds declarations only.
package prim_onehot_mon_pkg;

    // Pairwise Hamming distance 4, so a single flipped bit never lands on another legal state.
    typedef enum logic [5:0] {
        StOk    = 6'b110100,
        StErr   = 6'b001110,
        StFatal = 6'b011001
    } state_e;

    // Lowest bit of channel 'chan' in a flattened bus of 'width'-bit slices.
    function automatic int unsigned chan_lsb(input int unsigned chan, input int unsigned width);
        return chan * width;
    endfunction

endpackage

// File: rtl/prim_onehot_tree_chk.sv
// Per-channel combinational one-hot checker built from balanced OR/AND trees.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the result is valid whenever the inputs are.
module prim_onehot_tree_chk #(
    parameter int unsigned AddrWidth   = 5,
    parameter int unsigned OneHotWidth = 2**AddrWidth,
    parameter bit          AddrCheck   = 1'b1,
    parameter bit          EnableCheck = 1'b1,
    parameter bit          StrictCheck = 1'b1
) (
    input  logic                   valid_i,
    input  logic [OneHotWidth-1:0] oh_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   en_i,
    output logic                   err_o
);

    // Leaves are padded to a power of two; node i has children 2i+1 and 2i+2.
    localparam int unsigned NumLeaves = 2**AddrWidth;
    localparam int unsigned NumNodes  = 2 * NumLeaves - 1;

    logic [NumLeaves-1:0] oh_pad;
    logic [NumNodes-1:0]  or_node;
    logic [NumNodes-1:0]  multi_node;
    logic                 oh_any;
    logic                 oh_multi;
    logic                 en_err;
    logic                 addr_err;

    // Zero-extend so out-of-range addresses select a zero bit.
    always_comb begin
        oh_pad = '0;
        oh_pad[OneHotWidth-1:0] = oh_i;
    end

    // Reduce bottom-up: OR of the subtree, and whether two or more bits are set in it.
    always_comb begin
        or_node    = '0;
        multi_node = '0;
        or_node[NumNodes-1:NumLeaves-1] = oh_pad;
        for (int i = int'(NumLeaves) - 2; i >= 0; i--) begin
            or_node[i]    = or_node[2*i+1] | or_node[2*i+2];
            multi_node[i] = multi_node[2*i+1] | multi_node[2*i+2]
                          | (or_node[2*i+1] & or_node[2*i+2]);
        end
    end

    assign oh_any   = or_node[0];
    assign oh_multi = multi_node[0];

    // Enable and position checks; disabled checks contribute nothing.
    always_comb begin
        en_err   = 1'b0;
        addr_err = 1'b0;
        if (EnableCheck) begin
            en_err = StrictCheck ? (oh_any ^ en_i) : (~en_i & oh_any);
        end
        if (AddrCheck) begin
            addr_err = oh_any ^ oh_pad[addr_i];
        end
    end

    assign err_o = valid_i & (oh_multi | en_err | addr_err);

endmodule

// File: rtl/prim_onehot_mon.sv
// Multi-channel one-hot integrity monitor with sticky errors, event counter and terminal fatal state.
// Latency: 1 cycle from a faulty input to err_o / err_sticky_o / err_cnt_o / fatal_o.
// Backpressure: none; every channel is sampled every cycle when valid.
module prim_onehot_mon
    import prim_onehot_mon_pkg::*;
#(
    parameter int unsigned NumChannels    = 4,
    parameter int unsigned AddrWidth      = 5,
    parameter int unsigned OneHotWidth    = 2**AddrWidth,
    parameter bit          AddrCheck      = 1'b1,
    parameter bit          EnableCheck    = 1'b1,
    parameter bit          StrictCheck    = 1'b1,
    parameter int unsigned CntWidth       = 8,
    parameter int unsigned FatalThreshold = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumChannels-1:0]             valid_i,
    input  logic [NumChannels*OneHotWidth-1:0] oh_i,
    input  logic [NumChannels*AddrWidth-1:0]   addr_i,
    input  logic [NumChannels-1:0]             en_i,
    input  logic                               clr_i,
    output logic [NumChannels-1:0]             err_o,
    output logic [NumChannels-1:0]             err_sticky_o,
    output logic [CntWidth-1:0]                err_cnt_o,
    output logic                               fatal_o
);

    if (OneHotWidth < 1 || OneHotWidth > 2**AddrWidth) begin : g_bad_width
        $fatal(1, "OneHotWidth must be in 1..2**AddrWidth");
    end
    if (AddrCheck && !EnableCheck) begin : g_bad_check
        $fatal(1, "AddrCheck needs EnableCheck");
    end
    if (FatalThreshold < 1 || (FatalThreshold >> CntWidth) != 0) begin : g_bad_thr
        $fatal(1, "FatalThreshold must be in 1..2**CntWidth-1");
    end

    localparam logic [CntWidth-1:0] CntMax   = '1;
    localparam logic [CntWidth-1:0] FatalThr = CntWidth'(FatalThreshold);

    logic [NumChannels-1:0] err_d;
    logic [NumChannels-1:0] err_q;
    logic [NumChannels-1:0] sticky_d;
    logic [NumChannels-1:0] sticky_q;
    logic [CntWidth-1:0]    cnt_d;
    logic [CntWidth-1:0]    cnt_q;
    logic [CntWidth-1:0]    cnt_inc;
    logic                   any_err;
    logic                   in_fatal;
    state_e                 state_d;
    logic [5:0]             state_q;

    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        prim_onehot_tree_chk #(
            .AddrWidth   (AddrWidth),
            .OneHotWidth (OneHotWidth),
            .AddrCheck   (AddrCheck),
            .EnableCheck (EnableCheck),
            .StrictCheck (StrictCheck)
        ) u_chk (
            .valid_i (valid_i[c]),
            .oh_i    (oh_i[chan_lsb(c, OneHotWidth) +: OneHotWidth]),
            .addr_i  (addr_i[chan_lsb(c, AddrWidth) +: AddrWidth]),
            .en_i    (en_i[c]),
            .err_o   (err_d[c])
        );
    end

    assign any_err  = |err_d;
    // Anything other than Ok/Err, including corrupted encodings, is treated as Fatal.
    assign in_fatal = (state_q != StOk) && (state_q != StErr);

    // Counter and sticky next-state; clear is honoured only outside Fatal, and new errors win.
    always_comb begin
        cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntWidth'(1);
        cnt_d    = cnt_q;
        sticky_d = sticky_q | err_d;
        if (clr_i && !in_fatal) begin
            cnt_d    = any_err ? CntWidth'(1) : '0;
            sticky_d = err_d;
        end else if (any_err) begin
            cnt_d = cnt_inc;
        end
    end

    // Escalation FSM; reaching the threshold takes priority over Ok/Err moves.
    always_comb begin
        state_d = StFatal;
        case (state_q)
            StOk: begin
                if (cnt_d >= FatalThr) state_d = StFatal;
                else if (any_err)      state_d = StErr;
                else                   state_d = StOk;
            end
            StErr: begin
                if (cnt_d >= FatalThr)      state_d = StFatal;
                else if (clr_i && !any_err) state_d = StOk;
                else                        state_d = StErr;
            end
            default: state_d = StFatal;
        endcase
    end

    // All monitor state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q    <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
            state_q  <= StOk;
        end else begin
            err_q    <= err_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    assign err_o        = err_q;
    assign err_sticky_o = sticky_q;
    assign err_cnt_o    = cnt_q;
    assign fatal_o      = in_fatal;

endmodule
